// File: rtl/fft_agu_pipelined.sv
// Address-generation unit for an in-place radix-2 ping-pong FFT.
// Issues A/B read addresses and the twiddle index for each butterfly, and
// delays the read addresses by BF_LAT cycles so that they can be reused as
// write-back addresses. Each level drains before the next one starts.
module fft_agu_pipelined #(
  parameter int LOG2N  = 9,
  parameter int BF_LAT = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic                           stall_i,
  output logic [LOG2N-1:0]               rd_addr_a_o,
  output logic [LOG2N-1:0]               rd_addr_b_o,
  output logic [LOG2N-2:0]               tw_addr_o,
  output logic                           rd_valid_o,
  output logic                           rd_bank_o,
  output logic [LOG2N-1:0]               wr_addr_a_o,
  output logic [LOG2N-1:0]               wr_addr_b_o,
  output logic                           wr_en0_o,
  output logic                           wr_en1_o,
  output logic [$clog2(LOG2N+1)-1:0]     level_o,
  output logic                           busy_o,
  output logic                           done_o
);
  localparam int JW = LOG2N - 1;
  localparam int LW = $clog2(LOG2N + 1);
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [JW-1:0] JMAX = {JW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic             bank;
  } wr_ent_t;

  state_t          state_q;
  logic [JW-1:0]   j_q;
  logic [LW-1:0]   lvl_q;
  logic [DW-1:0]   dcnt_q;

  // Level/butterfly sequencing: RUN issues N/2 butterflies, DRAIN waits BF_LAT
  // non-stalled cycles so the level's last write lands before the next level reads.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      lvl_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RUN;
            j_q     <= '0;
            lvl_q   <= '0;
          end
        end
        S_RUN: begin
          if (!stall_i) begin
            j_q <= j_q + 1'b1;
            if (j_q == JMAX) begin
              state_q <= S_DRAIN;
              dcnt_q  <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (!stall_i) begin
            if (dcnt_q == DW'(BF_LAT - 1)) begin
              dcnt_q <= '0;
              j_q    <= '0;
              if (lvl_q == LW'(LOG2N - 1)) begin
                state_q <= S_DONE;
              end else begin
                lvl_q   <= lvl_q + 1'b1;
                state_q <= S_RUN;
              end
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          lvl_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Rotate-left within LOG2N bits; s is always below LOG2N, and a shift by
  // exactly LOG2N (s==0) yields zero so the OR term vanishes.
  function automatic logic [LOG2N-1:0] rotl(input logic [LOG2N-1:0] x,
                                            input logic [LW-1:0]    s);
    return (x << s) | (x >> (LW'(LOG2N) - s));
  endfunction

  logic             rd_vld;
  logic [LOG2N-1:0] a_raw, b_raw;
  logic [LW-1:0]    tw_sh;
  logic [JW-1:0]    tw_mask;

  // Read-side addresses are combinational from j/level and forced to 0 when not issuing.
  always_comb begin
    rd_vld      = (state_q == S_RUN) && !stall_i;
    a_raw       = {j_q, 1'b0};
    b_raw       = {j_q, 1'b1};
    tw_sh       = LW'(LOG2N - 1) - lvl_q;
    tw_mask     = JMAX << tw_sh;
    rd_addr_a_o = rd_vld ? rotl(a_raw, lvl_q) : '0;
    rd_addr_b_o = rd_vld ? rotl(b_raw, lvl_q) : '0;
    tw_addr_o   = rd_vld ? (j_q & tw_mask) : '0;
  end

  assign rd_valid_o = rd_vld;
  assign rd_bank_o  = lvl_q[0];
  assign level_o    = lvl_q;
  assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);

  logic [BF_LAT-1:0] vld_pipe_q;
  wr_ent_t           pipe_q [BF_LAT];

  // Write-back pipe: one stage per cycle of butterfly latency, frozen by stall.
  for (genvar s = 0; s < BF_LAT; s++) begin : g_stage
    wr_ent_t in_ent;
    logic    in_vld;
    if (s == 0) begin : g_head
      assign in_vld = rd_vld;
      assign in_ent = '{a: rd_addr_a_o, b: rd_addr_b_o, bank: lvl_q[0]};
    end else begin : g_body
      assign in_vld = vld_pipe_q[s-1];
      assign in_ent = pipe_q[s-1];
    end
    // Shift this stage on every non-stalled cycle.
    always_ff @(posedge clk_i) begin
      if (!reset_i) begin
        vld_pipe_q[s] <= 1'b0;
        pipe_q[s]     <= '0;
      end else if (!stall_i) begin
        vld_pipe_q[s] <= in_vld;
        pipe_q[s]     <= in_ent;
      end
    end
  end

  // Writes go to the bank opposite the one read at issue time.
  assign wr_addr_a_o = pipe_q[BF_LAT-1].a;
  assign wr_addr_b_o = pipe_q[BF_LAT-1].b;
  assign wr_en0_o    = vld_pipe_q[BF_LAT-1] &  pipe_q[BF_LAT-1].bank & !stall_i;
  assign wr_en1_o    = vld_pipe_q[BF_LAT-1] & !pipe_q[BF_LAT-1].bank & !stall_i;

endmodule
